ddr_a2m_burst_split: RTL and testbench
======================================

Name: ddr_a2m_burst_split

Overview:
Parametrised successor of the AXI-to-MBA total-size calculation. Accepts one AXI address-channel command at a time, computes its true byte total (unaligned-start aware, sizes up to the configured data width), and splits it into a sequence of chunk-aligned MBA commands under a valid/ready handshake. Sits between the AXI AR/AW slave front end and the MBA command issue logic.

Parameters:
ADDR_W, 32, address width.
ID_W, 4, AXI ID width carried to each chunk.
DATA_BYTES_LOG2, 4, largest legal AXSIZE (log2 of bus bytes).
CHUNK_LOG2, 6, log2 of maximum MBA chunk bytes; must be >= DATA_BYTES_LOG2 and <= 12.
TOTAL_W, 9+DATA_BYTES_LOG2 (derived), width of byte total.

Ports:
ACLK  in  1  clock.
ARST  in  1  asynchronous active-high reset.
AXVALID  in  1  command valid.
AXREADY  out  1  command ready.
AXADDR  in  ADDR_W  start address.
AXLEN  in  8  beats minus one.
AXSIZE  in  3  log2 bytes per beat.
AXBURST  in  2  00 FIXED, 01 INCR, 10 WRAP.
AXID  in  ID_W  transaction ID.
CMD_VALID  out  1  chunk valid.
CMD_READY  in  1  chunk accepted.
CMD_ADDR  out  ADDR_W  chunk start address.
CMD_BYTES  out  CHUNK_LOG2+1  chunk byte count (1..2^CHUNK_LOG2).
CMD_ID  out  ID_W  copy of AXID.
CMD_FIRST  out  1  first chunk of burst.
CMD_LAST  out  1  last chunk of burst.
TOTAL  out  TOTAL_W  byte total of burst in progress.
ERR  out  1  one-cycle error pulse.

Behaviour:
- Clock ACLK; reset ARST asynchronous, active-high. Reset values: state IDLE, CMD_VALID 0, CMD_ADDR/CMD_BYTES/CMD_ID/TOTAL 0, CMD_FIRST/CMD_LAST 0, ERR 0. AXREADY is 0 while ARST is high.
- States: IDLE and SPLIT. AXREADY = (state==IDLE) and not ARST.
- Accept in IDLE on AXVALID&AXREADY at cycle N:
  - Register addr, size, burst and id.
  - TOTAL = ((AXLEN+1) << AXSIZE) - (AXADDR mod 2^AXSIZE), computed at TOTAL_W bits.
  - Enter SPLIT with CMD_VALID=1 and CMD_FIRST=1 at N+1.
- Illegal AXSIZE > DATA_BYTES_LOG2: accepted, ERR=1 at N+1, no chunk emitted, stay IDLE.
- Chunk size:
  - INCR: CMD_BYTES = min(remaining, 2^CHUNK_LOG2 - (addr mod 2^CHUNK_LOG2)). Chunks never cross a chunk boundary and therefore never cross 4KB.
  - FIXED: each beat is one chunk of 2^AXSIZE bytes (first beat reduced by the unaligned offset) at the constant AXADDR; AXLEN+1 chunks.
- On CMD_VALID&CMD_READY:
  - addr += CMD_BYTES (INCR only); remaining -= CMD_BYTES.
  - New chunk registered for the next cycle. CMD_FIRST clears after the first chunk.
  - CMD_LAST=1 when CMD_BYTES == remaining. Acceptance of the last chunk returns the block to IDLE; AXREADY rises the next cycle.
- Throughput: one chunk per cycle while CMD_READY is high. Minimum of 1 idle cycle between bursts.
- Backpressure: while CMD_VALID & !CMD_READY, all CMD_* outputs are held stable.
- TOTAL holds the last accepted burst's total until the next accept.
- ARST mid-burst: in-flight burst is dropped immediately; no CMD_LAST is issued.
- All arithmetic is unsigned. Address increments wrap modulo 2^ADDR_W.

Optional Feature:
DDR_A2M_SPLIT_WRAP_EN.
- Defined: WRAP bursts are legal.
  - Requires AXLEN in {1,3,7,15} and addr aligned to 2^AXSIZE; otherwise ERR pulses and no chunk is emitted.
  - Wrap region = TOTAL bytes aligned down from AXADDR.
  - Chunk size is additionally limited by bytes remaining to the wrap upper bound.
  - On reaching the upper bound, addr reloads to the wrap base.
- Undefined: a WRAP burst pulses ERR at N+1 and is split exactly as INCR from AXADDR.

Test Plan:
- INCR 0x1000, len 3, size 4 -> one chunk: addr 0x1000, 64 bytes, FIRST=LAST=1, TOTAL=64.
- INCR 0x1030, len 7, size 4 -> chunks (0x1030,16,FIRST), (0x1040,64), (0x1080,48,LAST). TOTAL=128.
- INCR unaligned 0x1005, len 1, size 3 -> TOTAL=11; single chunk (0x1005,11,FIRST,LAST).
- FIXED 0x2000, len 2, size 2 -> three chunks of (0x2000,4 bytes), LAST on the third. Then hold CMD_READY low 5 cycles mid-burst -> outputs stable, no chunk lost.
- AXSIZE=5 -> ERR 1-cycle pulse, no CMD_VALID, AXREADY high next cycle. Assert ARST mid-burst -> CMD_VALID 0 immediately, AXREADY high after release.
- WRAP 0x3030, len 3, size 4:
  - With macro -> (0x3030,16,FIRST), (0x3000,48,LAST).
  - Without macro -> ERR pulse plus (0x3030,16), (0x3040,48,LAST).

Source files
------------

// File: rtl/ddr_a2m_burst_split.sv
// ddr_a2m_burst_split
//   Takes one AXI address-channel command at a time, computes its byte total
//   (reduced by the unaligned start offset), and emits it as a series of
//   chunk-aligned MBA commands over a valid/ready handshake.
//
// Optional feature macro: DDR_A2M_SPLIT_WRAP_EN
//   defined   : WRAP bursts are split inside their wrap window
//   undefined : WRAP bursts pulse ERR and are split as INCR
//
// Ports
//   ACLK, ARST                 clock, asynchronous active-high reset
//   AXVALID/AXREADY            command handshake (ready only in IDLE)
//   AXADDR/AXLEN/AXSIZE/AXBURST/AXID  AXI command fields
//   CMD_VALID/CMD_READY        chunk handshake
//   CMD_ADDR/CMD_BYTES/CMD_ID  chunk address, byte count (1..2^CHUNK_LOG2), id
//   CMD_FIRST/CMD_LAST         first / last chunk markers
//   TOTAL                      byte total of the most recently accepted burst
//   ERR                        one-cycle pulse for an illegal command
module ddr_a2m_burst_split #(
  parameter int ADDR_W          = 32,
  parameter int ID_W            = 4,
  parameter int DATA_BYTES_LOG2 = 4,
  parameter int CHUNK_LOG2      = 6,
  parameter int TOTAL_W         = 9 + DATA_BYTES_LOG2
) (
  input  logic                  ACLK,
  input  logic                  ARST,
  input  logic                  AXVALID,
  output logic                  AXREADY,
  input  logic [ADDR_W-1:0]     AXADDR,
  input  logic [7:0]            AXLEN,
  input  logic [2:0]            AXSIZE,
  input  logic [1:0]            AXBURST,
  input  logic [ID_W-1:0]       AXID,
  output logic                  CMD_VALID,
  input  logic                  CMD_READY,
  output logic [ADDR_W-1:0]     CMD_ADDR,
  output logic [CHUNK_LOG2:0]   CMD_BYTES,
  output logic [ID_W-1:0]       CMD_ID,
  output logic                  CMD_FIRST,
  output logic                  CMD_LAST,
  output logic [TOTAL_W-1:0]    TOTAL,
  output logic                  ERR
);

  localparam int CB_W = CHUNK_LOG2 + 1;
  // working width for chunk arithmetic: holds both a byte total and a full chunk
  localparam int WW = ((TOTAL_W > CB_W) ? TOTAL_W : CB_W) + 1;

  typedef enum logic {ST_IDLE, ST_SPLIT} state_t;
  typedef enum logic [1:0] {M_INCR, M_FIXED, M_WRAP} mode_t;

  state_t               state_q, nxt_state;
  mode_t                mode_q, nxt_mode, acc_mode;
  logic [2:0]           size_q, nxt_size;
  logic [TOTAL_W-1:0]   rem_q, nxt_rem;
  logic [ADDR_W-1:0]    addr_q, nxt_addr;
  logic [CB_W-1:0]      bytes_q, nxt_bytes;
  logic [ID_W-1:0]      id_q, nxt_id;
  logic                 first_q, nxt_first;
  logic                 last_q, nxt_last;
  logic                 valid_q, nxt_valid;
  logic [TOTAL_W-1:0]   total_q, nxt_total;
  logic                 err_q, nxt_err;

  logic [ADDR_W-1:0]    acc_off;
  logic [TOTAL_W-1:0]   acc_total;
  logic                 size_bad, is_wrap, acc_fatal, acc_warn;
  logic [WW-1:0]        acc_wdist, adv_wdist;
  logic [CB_W-1:0]      acc_bytes, adv_bytes;
  logic [ADDR_W-1:0]    adv_addr;
  logic [TOTAL_W-1:0]   adv_rem;

  // Chunk length: FIXED takes the partial first beat then whole beats;
  // INCR/WRAP stop at the chunk boundary, the remaining total and the wrap
  // upper bound (wdist is all-ones when no wrap limit applies).
  function automatic logic [CB_W-1:0] chunk_len(
    input logic [CHUNK_LOG2-1:0] a_lo,
    input logic [TOTAL_W-1:0]    rem,
    input mode_t                 m,
    input logic [2:0]            sz,
    input logic [WW-1:0]         wdist
  );
    logic [WW-1:0] r, pw, part, lim;
    r    = WW'(rem);
    pw   = WW'(1) << sz;
    part = r & (pw - WW'(1));
    if (m == M_FIXED) begin
      lim = (part == '0) ? pw : part;
    end else begin
      lim = (WW'(1) << CHUNK_LOG2) - WW'(a_lo);
      if (r < lim)     lim = r;
      if (wdist < lim) lim = wdist;
    end
    return CB_W'(lim);
  endfunction

  assign acc_off   = AXADDR & ((ADDR_W'(1) << AXSIZE) - ADDR_W'(1));
  assign acc_total = ((TOTAL_W'(AXLEN) + TOTAL_W'(1)) << AXSIZE) - TOTAL_W'(acc_off);
  assign size_bad  = 32'(AXSIZE) > DATA_BYTES_LOG2;
  assign is_wrap   = (AXBURST == 2'b10);

`ifdef DDR_A2M_SPLIT_WRAP_EN
  logic [ADDR_W-1:0] wrap_base_q, wrap_hi_q, nxt_wrap_base, nxt_wrap_hi;
  logic [ADDR_W-1:0] acc_base, acc_hi, adv_seq;
  logic              wrap_bad;

  assign wrap_bad  = is_wrap && (!(AXLEN inside {8'd1, 8'd3, 8'd7, 8'd15}) || (acc_off != '0));
  assign acc_fatal = size_bad || wrap_bad;
  assign acc_warn  = 1'b0;
  assign acc_mode  = is_wrap ? M_WRAP : ((AXBURST == 2'b00) ? M_FIXED : M_INCR);
  // legal wrap totals are powers of two, so the window base is an alignment mask
  assign acc_base  = AXADDR & ~(ADDR_W'(acc_total) - ADDR_W'(1));
  assign acc_hi    = acc_base + ADDR_W'(acc_total);
  assign acc_wdist = is_wrap ? WW'(acc_hi - AXADDR) : '1;

  assign adv_seq   = (mode_q == M_FIXED) ? addr_q : addr_q + ADDR_W'(bytes_q);
  assign adv_addr  = ((mode_q == M_WRAP) && (adv_seq == wrap_hi_q)) ? wrap_base_q : adv_seq;
  assign adv_wdist = (mode_q == M_WRAP) ? WW'(wrap_hi_q - adv_addr) : '1;
`else
  assign acc_fatal = size_bad;
  assign acc_warn  = is_wrap;
  assign acc_mode  = (AXBURST == 2'b00) ? M_FIXED : M_INCR;
  assign acc_wdist = '1;
  assign adv_addr  = (mode_q == M_FIXED) ? addr_q : addr_q + ADDR_W'(bytes_q);
  assign adv_wdist = '1;
`endif

  assign adv_rem   = rem_q - TOTAL_W'(bytes_q);
  assign acc_bytes = chunk_len(AXADDR[CHUNK_LOG2-1:0], acc_total, acc_mode, AXSIZE, acc_wdist);
  assign adv_bytes = chunk_len(adv_addr[CHUNK_LOG2-1:0], adv_rem, mode_q, size_q, adv_wdist);

  always_comb begin
    nxt_state = state_q;
    nxt_mode  = mode_q;
    nxt_size  = size_q;
    nxt_rem   = rem_q;
    nxt_addr  = addr_q;
    nxt_bytes = bytes_q;
    nxt_id    = id_q;
    nxt_first = first_q;
    nxt_last  = last_q;
    nxt_valid = valid_q;
    nxt_total = total_q;
    nxt_err   = 1'b0;
`ifdef DDR_A2M_SPLIT_WRAP_EN
    nxt_wrap_base = wrap_base_q;
    nxt_wrap_hi   = wrap_hi_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (AXVALID) begin
          nxt_total = acc_total;
          nxt_id    = AXID;
          nxt_addr  = AXADDR;
          nxt_mode  = acc_mode;
          nxt_size  = AXSIZE;
          nxt_rem   = acc_total;
          nxt_err   = acc_fatal || acc_warn;
`ifdef DDR_A2M_SPLIT_WRAP_EN
          nxt_wrap_base = acc_base;
          nxt_wrap_hi   = acc_hi;
`endif
          if (!acc_fatal) begin
            nxt_state = ST_SPLIT;
            nxt_valid = 1'b1;
            nxt_first = 1'b1;
            nxt_bytes = acc_bytes;
            nxt_last  = (TOTAL_W'(acc_bytes) == acc_total);
          end
        end
      end
      ST_SPLIT: begin
        if (CMD_READY) begin
          if (last_q) begin
            nxt_state = ST_IDLE;
            nxt_valid = 1'b0;
            nxt_first = 1'b0;
            nxt_last  = 1'b0;
          end else begin
            nxt_addr  = adv_addr;
            nxt_rem   = adv_rem;
            nxt_bytes = adv_bytes;
            nxt_first = 1'b0;
            nxt_last  = (TOTAL_W'(adv_bytes) == adv_rem);
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state_q <= ST_IDLE;
      mode_q  <= M_INCR;
      size_q  <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      bytes_q <= '0;
      id_q    <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      total_q <= '0;
      err_q   <= 1'b0;
`ifdef DDR_A2M_SPLIT_WRAP_EN
      wrap_base_q <= '0;
      wrap_hi_q   <= '0;
`endif
    end else begin
      state_q <= nxt_state;
      mode_q  <= nxt_mode;
      size_q  <= nxt_size;
      rem_q   <= nxt_rem;
      addr_q  <= nxt_addr;
      bytes_q <= nxt_bytes;
      id_q    <= nxt_id;
      first_q <= nxt_first;
      last_q  <= nxt_last;
      valid_q <= nxt_valid;
      total_q <= nxt_total;
      err_q   <= nxt_err;
`ifdef DDR_A2M_SPLIT_WRAP_EN
      wrap_base_q <= nxt_wrap_base;
      wrap_hi_q   <= nxt_wrap_hi;
`endif
    end
  end

  assign AXREADY   = (state_q == ST_IDLE) && !ARST;
  assign CMD_VALID = valid_q;
  assign CMD_ADDR  = addr_q;
  assign CMD_BYTES = bytes_q;
  assign CMD_ID    = id_q;
  assign CMD_FIRST = first_q;
  assign CMD_LAST  = last_q;
  assign TOTAL     = total_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_ddr_a2m_burst_split.sv
module tb_ddr_a2m_burst_split;

  localparam int ADDR_W          = 32;
  localparam int ID_W            = 4;
  localparam int DATA_BYTES_LOG2 = 4;
  localparam int CHUNK_LOG2      = 6;
  localparam int TOTAL_W         = 9 + DATA_BYTES_LOG2;

  logic                ACLK, ARST;
  logic                AXVALID, AXREADY;
  logic [ADDR_W-1:0]   AXADDR;
  logic [7:0]          AXLEN;
  logic [2:0]          AXSIZE;
  logic [1:0]          AXBURST;
  logic [ID_W-1:0]     AXID;
  logic                CMD_VALID, CMD_READY;
  logic [ADDR_W-1:0]   CMD_ADDR;
  logic [CHUNK_LOG2:0] CMD_BYTES;
  logic [ID_W-1:0]     CMD_ID;
  logic                CMD_FIRST, CMD_LAST;
  logic [TOTAL_W-1:0]  TOTAL;
  logic                ERR;

  ddr_a2m_burst_split #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_BYTES_LOG2(DATA_BYTES_LOG2),
    .CHUNK_LOG2(CHUNK_LOG2), .TOTAL_W(TOTAL_W)
  ) dut (
    .ACLK(ACLK), .ARST(ARST),
    .AXVALID(AXVALID), .AXREADY(AXREADY), .AXADDR(AXADDR), .AXLEN(AXLEN),
    .AXSIZE(AXSIZE), .AXBURST(AXBURST), .AXID(AXID),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR),
    .CMD_BYTES(CMD_BYTES), .CMD_ID(CMD_ID), .CMD_FIRST(CMD_FIRST),
    .CMD_LAST(CMD_LAST), .TOTAL(TOTAL), .ERR(ERR)
  );

  typedef struct {
    logic [31:0] addr;
    int          bytes;
    logic [3:0]  id;
    bit          first;
    bit          last;
  } chunk_t;

  chunk_t      exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          err_seen = 0;
  int          err_exp = 0;
  int          force_low = 0;
  bit          rand_ready = 0;
  bit          holding = 0;
  logic [45:0] snap;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: byte total from the command fields; INCR/WRAP chunks found by
  // walking the byte addresses and cutting at every discontinuity or 64-byte line.
  task automatic model_burst(input logic [31:0] addr, input int len, input int size,
                             input int burst, input logic [3:0] id,
                             output int total, output bit fatal, output bit errx);
    int unsigned off;
    bit          wrapm;
    logic [31:0] base, a, prev, start;
    int          cnt;
    chunk_t      tmp[$];
    chunk_t      c;
    off   = addr % (32'd1 << size);
    total = (((len + 1) << size) - int'(off)) & 'h1fff;
    fatal = (size > DATA_BYTES_LOG2);
    wrapm = 0;
`ifdef DDR_A2M_SPLIT_WRAP_EN
    if (burst == 2) begin
      wrapm = 1;
      if (!(len == 1 || len == 3 || len == 7 || len == 15) || off != 0) fatal = 1;
    end
    errx = fatal;
`else
    errx = fatal || (burst == 2);
`endif
    if (fatal) return;
    if (burst == 0) begin
      for (int b = 0; b <= len; b++) begin
        c.addr = addr;
        c.bytes = (b == 0) ? ((1 << size) - int'(off)) : (1 << size);
        c.id = id; c.first = 0; c.last = 0;
        tmp.push_back(c);
      end
    end else begin
      base  = wrapm ? (addr & ~(32'(total) - 32'd1)) : addr;
      start = addr; prev = addr; cnt = 0;
      for (int i = 0; i < total; i++) begin
        a = wrapm ? base + ((addr - base + 32'(i)) % 32'(total)) : addr + 32'(i);
        if (cnt > 0 && (a != prev + 32'd1 || (a % 64) == 0)) begin
          c.addr = start; c.bytes = cnt; c.id = id; c.first = 0; c.last = 0;
          tmp.push_back(c);
          start = a; cnt = 0;
        end
        cnt++;
        prev = a;
      end
      c.addr = start; c.bytes = cnt; c.id = id; c.first = 0; c.last = 0;
      tmp.push_back(c);
    end
    tmp[0].first = 1;
    tmp[tmp.size()-1].last = 1;
    foreach (tmp[k]) exp_q.push_back(tmp[k]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("burst_timeout", 64'(exp_q.size()), 0);
      exp_q.delete();
    end
    @(negedge ACLK);
    chk("axready_after_burst", AXREADY, 1);
  endtask

  task automatic issue(input logic [31:0] addr, input int len, input int size,
                       input int burst, input logic [3:0] id, input bit do_wait);
    int total, n;
    bit fatal, errx;
    model_burst(addr, len, size, burst, id, total, fatal, errx);
    if (errx) err_exp++;
    n = 0;
    @(negedge ACLK);
    while (!AXREADY && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    chk("axready_wait", AXREADY, 1);
    AXVALID = 1; AXADDR = addr; AXLEN = 8'(len); AXSIZE = 3'(size);
    AXBURST = 2'(burst); AXID = id;
    @(posedge ACLK);
    #1 AXVALID = 0;
    @(negedge ACLK);
    chk("err", ERR, errx);
    chk("total", TOTAL, 64'(total));
    chk("cmd_valid_after_accept", CMD_VALID, !fatal);
    chk("axready_after_accept", AXREADY, fatal);
    if (do_wait) wait_done();
  endtask

  // CMD_READY driver: forced-low window, random, or always high
  initial begin
    CMD_READY = 1;
    forever begin
      @(posedge ACLK);
      #1;
      if (force_low > 0) begin
        CMD_READY = 0;
        force_low--;
      end else begin
        CMD_READY = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks held outputs under backpressure
  always @(negedge ACLK) begin
    if (ARST) begin
      holding = 0;
    end else begin
      if (ERR) err_seen++;
      if (holding)
        chk("hold_stable", {CMD_VALID, CMD_ADDR, CMD_BYTES, CMD_ID, CMD_FIRST, CMD_LAST}, snap);
      if (CMD_VALID && !CMD_READY) begin
        holding = 1;
        snap = {CMD_VALID, CMD_ADDR, CMD_BYTES, CMD_ID, CMD_FIRST, CMD_LAST};
      end else begin
        holding = 0;
      end
      if (CMD_VALID && CMD_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_chunk actual addr=%0h bytes=%0d required none", CMD_ADDR, CMD_BYTES);
        end else begin
          chunk_t e;
          e = exp_q.pop_front();
          chk("chunk", {CMD_ADDR, CMD_BYTES, CMD_ID, CMD_FIRST, CMD_LAST},
              {e.addr, 7'(e.bytes), e.id, e.first, e.last});
        end
      end
    end
  end

  initial begin
    logic [31:0] ra;
    int rlen, rsize, rburst, r;
    ARST = 1; AXVALID = 0; AXADDR = '0; AXLEN = '0; AXSIZE = '0; AXBURST = '0; AXID = '0;
    repeat (3) @(negedge ACLK);
    chk("rst_axready", AXREADY, 0);
    chk("rst_outputs", {CMD_VALID, CMD_ADDR, CMD_BYTES, CMD_ID, CMD_FIRST, CMD_LAST, TOTAL, ERR}, 0);
    #2 ARST = 0;
    @(negedge ACLK);
    chk("axready_after_reset", AXREADY, 1);

    issue(32'h1000, 3, 4, 1, 4'h1, 1);
    issue(32'h1030, 7, 4, 1, 4'h2, 1);
    issue(32'h1005, 1, 3, 1, 4'h3, 1);
    issue(32'h2000, 2, 2, 0, 4'h4, 0);
    force_low = 5;
    wait_done();
    issue(32'h0, 0, 5, 1, 4'h5, 1);
    issue(32'h3030, 3, 4, 2, 4'h6, 1);
    issue(32'h0000_0ff8, 15, 3, 1, 4'h7, 1);
    issue(32'hffff_fff0, 3, 4, 1, 4'h8, 1);

    rand_ready = 1;
    for (int t = 0; t < 150; t++) begin
      ra = $urandom;
      if ($urandom_range(3) == 0) ra = {ra[31:12], 6'h3f, ra[5:0]};
      r = $urandom_range(0, 9);
      rsize  = (r < 8) ? (r % 5) : $urandom_range(5, 7);
      rburst = $urandom_range(0, 2);
      rlen   = ($urandom_range(1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
      if (rburst == 2 && $urandom_range(3) != 0) begin
        r = $urandom_range(0, 3);
        rlen = (2 << r) - 1;
        ra = ra & ~((32'd1 << rsize) - 32'd1);
      end
      issue(ra, rlen, rsize, rburst, 4'($urandom), 1);
    end

    rand_ready = 0;
    issue(32'h4000, 255, 4, 1, 4'h9, 0);
    repeat (4) @(negedge ACLK);
    #2 ARST = 1;
    #1;
    chk("rst_mid_valid", CMD_VALID, 0);
    chk("rst_mid_axready", AXREADY, 0);
    chk("rst_mid_last", CMD_LAST, 0);
    exp_q.delete();
    @(negedge ACLK);
    #2 ARST = 0;
    @(negedge ACLK);
    chk("axready_after_mid_reset", AXREADY, 1);
    issue(32'h5010, 4, 4, 1, 4'ha, 1);

    chk("err_pulses", 64'(err_seen), 64'(err_exp));
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
